// File: rtl/mask_unit_read_scheduler_if.sv
// rtl/mask_unit_read_scheduler_if.sv - requester, crossbar and lane-response bundle for the read scheduler
interface mask_unit_read_scheduler_if #(
    parameter int CNT_W = 2
);
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [19:0]        req_vs;
    logic [23:0]        req_offset;
    logic [7:0]         req_readLane;
    logic [7:0]         req_dataOffset;
    logic [3:0]         xbar_valid;
    logic [3:0]         xbar_ready;
    logic [19:0]        xbar_vs;
    logic [23:0]        xbar_offset;
    logic [7:0]         xbar_readLane;
    logic [7:0]         xbar_dataOffset;
    logic [3:0]         resp_valid;
    logic [4*CNT_W-1:0] credit;
    logic               busy;
    logic               credit_err;

    modport master (
        output req_valid, req_vs, req_offset, req_readLane, req_dataOffset,
        output xbar_ready, resp_valid,
        input  req_ready, xbar_valid, xbar_vs, xbar_offset, xbar_readLane, xbar_dataOffset,
        input  credit, busy, credit_err
    );

    modport slave (
        input  req_valid, req_vs, req_offset, req_readLane, req_dataOffset,
        input  xbar_ready, resp_valid,
        output req_ready, xbar_valid, xbar_vs, xbar_offset, xbar_readLane, xbar_dataOffset,
        output credit, busy, credit_err
    );
endinterface

// File: rtl/mask_unit_read_scheduler.sv
// rtl/mask_unit_read_scheduler.sv - holding stage, starvation override and per-lane credits for the 4x4 read crossbar
module mask_unit_read_scheduler #(
    parameter int STARVE_LIMIT = 8,
    parameter int CREDITS      = 2,
    parameter int CNT_W        = $clog2(CREDITS + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    mask_unit_read_scheduler_if.slave bus
);
    localparam logic [7:0]       AGE_MAX  = 8'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CRED_ONE = CNT_W'(1);

    logic [3:0]       holdValid;
    logic [4:0]       holdVs         [4];
    logic [5:0]       holdOffset     [4];
    logic [1:0]       holdLane       [4];
    logic [1:0]       holdDataOffset [4];
    logic [7:0]       age            [4];
    logic [CNT_W-1:0] cred           [4];
    logic             creditErr;

    logic [3:0] elig;
    logic [3:0] starved;
    logic [3:0] xbarValid;
    logic [3:0] fire;
    logic [3:0] reqReady;
    logic [3:0] load;
    logic [3:0] laneFire;
    logic       found;
    logic [1:0] sIdx;

    always_comb begin
        elig    = '0;
        starved = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i]    = holdValid[i] && (cred[holdLane[i]] != '0);
            starved[i] = elig[i] && (age[i] == AGE_MAX);
        end
    end

    // Descending scan leaves the lowest-index starved requester selected.
    always_comb begin
        found = 1'b0;
        sIdx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (starved[i]) begin
                found = 1'b1;
                sIdx  = 2'(i);
            end
        end
    end

    always_comb begin
        xbarValid = '0;
        for (int i = 0; i < 4; i++) begin
            xbarValid[i] = elig[i] &&
                           !(found && (sIdx != 2'(i)) && (holdLane[i] == holdLane[sIdx]));
        end
    end

    assign fire     = xbarValid & bus.xbar_ready;
    assign reqReady = flush ? 4'b0000 : (~holdValid | fire);
    assign load     = bus.req_valid & reqReady;

    always_comb begin
        laneFire = '0;
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) laneFire[holdLane[i]] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            holdValid <= '0;
            for (int i = 0; i < 4; i++) begin
                holdVs[i]         <= '0;
                holdOffset[i]     <= '0;
                holdLane[i]       <= '0;
                holdDataOffset[i] <= '0;
                age[i]            <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (flush) begin
                    holdValid[i] <= 1'b0;
                end else if (load[i]) begin
                    holdValid[i]      <= 1'b1;
                    holdVs[i]         <= bus.req_vs[i*5 +: 5];
                    holdOffset[i]     <= bus.req_offset[i*6 +: 6];
                    holdLane[i]       <= bus.req_readLane[i*2 +: 2];
                    holdDataOffset[i] <= bus.req_dataOffset[i*2 +: 2];
                end else if (fire[i]) begin
                    holdValid[i] <= 1'b0;
                end
                // A request loaded on its predecessor's fire cycle starts fresh at zero.
                if (flush || !holdValid[i] || fire[i]) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            creditErr <= 1'b0;
            for (int l = 0; l < 4; l++) cred[l] <= CRED_MAX;
        end else begin
            for (int l = 0; l < 4; l++) begin
                case ({laneFire[l], bus.resp_valid[l]})
                    2'b10: cred[l] <= cred[l] - CRED_ONE;
                    2'b01: begin
                        if (cred[l] == CRED_MAX) creditErr <= 1'b1;
                        else                     cred[l]   <= cred[l] + CRED_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.xbar_valid      = xbarValid;
        bus.req_ready       = reqReady;
        bus.busy            = |holdValid;
        bus.credit_err      = creditErr;
        bus.xbar_vs         = '0;
        bus.xbar_offset     = '0;
        bus.xbar_readLane   = '0;
        bus.xbar_dataOffset = '0;
        bus.credit          = '0;
        for (int i = 0; i < 4; i++) begin
            bus.xbar_vs[i*5 +: 5]         = holdVs[i];
            bus.xbar_offset[i*6 +: 6]     = holdOffset[i];
            bus.xbar_readLane[i*2 +: 2]   = holdLane[i];
            bus.xbar_dataOffset[i*2 +: 2] = holdDataOffset[i];
            bus.credit[i*CNT_W +: CNT_W]  = cred[i];
        end
    end
endmodule

// File: tb/tb_mask_unit_read_scheduler.sv
// tb/tb_mask_unit_read_scheduler.sv - randomized and directed checks against a request/outstanding-read model
module tb_mask_unit_read_scheduler;
    localparam int STARVE_LIMIT = 8;
    localparam int CREDITS      = 2;
    localparam int CNT_W        = $clog2(CREDITS + 1);

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] readyMask = 4'hF;

    mask_unit_read_scheduler_if #(.CNT_W(CNT_W)) bus ();

    mask_unit_read_scheduler #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CREDITS     (CREDITS),
        .CNT_W       (CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    // Fixed-priority crossbar: an input loses to any lower-index valid input on the same lane.
    always_comb begin
        bus.xbar_ready = readyMask;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < i; j++) begin
                if (bus.xbar_valid[j] && (bus.xbar_readLane[j*2 +: 2] == bus.xbar_readLane[i*2 +: 2]))
                    bus.xbar_ready[i] = 1'b0;
            end
        end
    end

    int checks = 0;
    int passes = 0;

    // Reference: each requester holds at most one pending request and counts the cycles it has waited;
    // each lane tracks reads in flight, and credit is what remains of the budget.
    bit       mHeld [4];
    logic [4:0] mVs [4];
    logic [5:0] mOff [4];
    logic [1:0] mLane [4];
    logic [1:0] mDo [4];
    int       mWait [4];
    int       mOut [4];
    bit       mErr;
    bit       nHeld [4];
    logic [4:0] nVs [4];
    logic [5:0] nOff [4];
    logic [1:0] nLane [4];
    logic [1:0] nDo [4];
    int       nWait [4];
    int       nOut [4];
    bit       nErr;

    logic [3:0]         lastXv, lastFire, lastReady;
    logic [4*CNT_W-1:0] lastCredit;
    logic               lastBusy, lastErr;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int credOf(input logic [4*CNT_W-1:0] v, input int l);
        return int'(v[l*CNT_W +: CNT_W]);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mHeld[i] = 0; mVs[i] = '0; mOff[i] = '0; mLane[i] = '0; mDo[i] = '0;
            mWait[i] = 0; mOut[i] = 0;
        end
        mErr = 0;
    endtask

    task automatic evalCycle();
        logic [3:0]         eXv, eFire, eRdy;
        logic [19:0]        eVs;
        logic [23:0]        eOff;
        logic [7:0]         eLane, eDo;
        logic [4*CNT_W-1:0] eCred;
        bit                 elig [4];
        bit                 issued [4];
        int                 s;
        s = -1;
        for (int i = 0; i < 4; i++) begin
            elig[i] = mHeld[i] && (mOut[mLane[i]] < CREDITS);
            if (s < 0 && elig[i] && mWait[i] == STARVE_LIMIT) s = i;
        end
        for (int i = 0; i < 4; i++) begin
            eXv[i]   = elig[i] && !(s >= 0 && i != s && mLane[i] == mLane[s]);
            eFire[i] = eXv[i] && bus.xbar_ready[i];
            eRdy[i]  = !flush && (!mHeld[i] || eFire[i]);
            eVs[i*5 +: 5]   = mVs[i];
            eOff[i*6 +: 6]  = mOff[i];
            eLane[i*2 +: 2] = mLane[i];
            eDo[i*2 +: 2]   = mDo[i];
            eCred[i*CNT_W +: CNT_W] = CNT_W'(CREDITS - mOut[i]);
        end
        checkVal("req_ready", 64'(bus.req_ready), 64'(eRdy));
        checkVal("xbar_valid", 64'(bus.xbar_valid), 64'(eXv));
        checkVal("xbar_vs", 64'(bus.xbar_vs), 64'(eVs));
        checkVal("xbar_offset", 64'(bus.xbar_offset), 64'(eOff));
        checkVal("xbar_readLane", 64'(bus.xbar_readLane), 64'(eLane));
        checkVal("xbar_dataOffset", 64'(bus.xbar_dataOffset), 64'(eDo));
        checkVal("credit", 64'(bus.credit), 64'(eCred));
        checkVal("busy", 64'(bus.busy), 64'(mHeld[0] | mHeld[1] | mHeld[2] | mHeld[3]));
        checkVal("credit_err", 64'(bus.credit_err), 64'(mErr));
        lastXv = bus.xbar_valid; lastFire = bus.xbar_valid & bus.xbar_ready;
        lastReady = bus.req_ready; lastCredit = bus.credit;
        lastBusy = bus.busy; lastErr = bus.credit_err;

        nErr = mErr;
        for (int l = 0; l < 4; l++) issued[l] = 0;
        for (int i = 0; i < 4; i++) begin
            if (eFire[i]) issued[mLane[i]] = 1;
            nHeld[i] = mHeld[i]; nVs[i] = mVs[i]; nOff[i] = mOff[i]; nLane[i] = mLane[i]; nDo[i] = mDo[i];
            if (flush) nHeld[i] = 0;
            else if (bus.req_valid[i] && eRdy[i]) begin
                nHeld[i] = 1;
                nVs[i]   = bus.req_vs[i*5 +: 5];
                nOff[i]  = bus.req_offset[i*6 +: 6];
                nLane[i] = bus.req_readLane[i*2 +: 2];
                nDo[i]   = bus.req_dataOffset[i*2 +: 2];
            end else if (eFire[i]) nHeld[i] = 0;
            if (mHeld[i] && !eFire[i] && !flush) nWait[i] = (mWait[i] < STARVE_LIMIT) ? mWait[i] + 1 : mWait[i];
            else nWait[i] = 0;
        end
        for (int l = 0; l < 4; l++) begin
            nOut[l] = mOut[l] + (issued[l] ? 1 : 0);
            if (bus.resp_valid[l]) begin
                if (nOut[l] == 0) nErr = 1;
                else nOut[l] = nOut[l] - 1;
            end
        end
    endtask

    task automatic commitModel();
        for (int i = 0; i < 4; i++) begin
            mHeld[i] = nHeld[i]; mVs[i] = nVs[i]; mOff[i] = nOff[i]; mLane[i] = nLane[i]; mDo[i] = nDo[i];
            mWait[i] = nWait[i]; mOut[i] = nOut[i];
        end
        mErr = nErr;
    endtask

    task automatic cycle();
        @(negedge clock);
        evalCycle();
        @(posedge clock);
        commitModel();
        #1;
    endtask

    task automatic idleInputs();
        bus.req_valid = '0; bus.req_vs = '0; bus.req_offset = '0;
        bus.req_readLane = '0; bus.req_dataOffset = '0; bus.resp_valid = '0;
        flush = 1'b0; readyMask = 4'hF;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_xbar_valid"}, 64'(bus.xbar_valid), 64'(0));
        checkVal({tag, "_busy"}, 64'(bus.busy), 64'(0));
        checkVal({tag, "_req_ready"}, 64'(bus.req_ready), 64'(4'hF));
        checkVal({tag, "_credit"}, 64'(bus.credit), 64'({4{CNT_W'(CREDITS)}}));
        checkVal({tag, "_credit_err"}, 64'(bus.credit_err), 64'(0));
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        #1;
        checkResetOutputs("reset");
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic randomInputs();
        bus.req_valid      = 4'($urandom);
        bus.req_vs         = 20'($urandom);
        bus.req_offset     = 24'($urandom);
        bus.req_readLane   = 8'($urandom);
        bus.req_dataOffset = 8'($urandom);
        readyMask          = 4'($urandom) | 4'($urandom);
        flush              = ($urandom_range(0, 31) == 0);
        for (int l = 0; l < 4; l++)
            bus.resp_valid[l] = (mOut[l] > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        int waits;
        bit fired;
        logic [4*CNT_W-1:0] savedCred;
        #1;
        doReset();

        // Single request to lane 1 from requester 2.
        bus.req_valid = 4'b0100; bus.req_readLane = 8'b00_01_00_00; bus.req_vs = 20'h3 << 10;
        cycle();
        bus.req_valid = '0;
        cycle();
        checkVal("t1_xbar_valid", 64'(lastXv), 64'(4'b0100));
        checkVal("t1_ready2", 64'(lastReady[2]), 64'(1));
        checkVal("t1_cred_before", 64'(credOf(lastCredit, 1)), 64'(2));
        cycle();
        checkVal("t1_cred_after", 64'(credOf(lastCredit, 1)), 64'(1));

        // Starvation: requesters 0 and 3 contend for lane 0 every cycle.
        doReset();
        bus.req_valid = 4'b1001; bus.req_readLane = 8'h00;
        cycle();
        bus.resp_valid = 4'b0001;
        for (int round = 0; round < 2; round++) begin
            waits = 0; fired = 0;
            for (int k = 0; k < 20 && !fired; k++) begin
                cycle();
                if (lastFire[3]) begin
                    fired = 1;
                    checkVal("starve_xv0", 64'(lastXv[0]), 64'(0));
                end else waits++;
            end
            checkVal("starve_fired", 64'(fired), 64'(1));
            checkVal("starve_wait", 64'(waits), 64'(STARVE_LIMIT));
        end
        checkVal("starve_no_err", 64'(lastErr), 64'(0));

        // Credit exhaustion on lane 2.
        doReset();
        bus.req_valid = 4'b0111; bus.req_readLane = 8'h2A;
        cycle();
        bus.req_valid = '0;
        cycle(); cycle(); cycle();
        checkVal("cred_blocked_xv", 64'(lastXv), 64'(0));
        checkVal("cred_lane2_zero", 64'(credOf(lastCredit, 2)), 64'(0));
        bus.resp_valid = 4'b0100;
        cycle();
        bus.resp_valid = '0;
        cycle();
        checkVal("cred_return_fire", 64'(lastFire), 64'(4'b0100));

        // Response overflow on lane 1.
        bus.resp_valid = 4'b0010;
        cycle();
        bus.resp_valid = '0;
        cycle();
        checkVal("overflow_err", 64'(lastErr), 64'(1));
        checkVal("overflow_cred", 64'(credOf(lastCredit, 1)), 64'(CREDITS));
        repeat (3) cycle();
        checkVal("overflow_sticky", 64'(lastErr), 64'(1));

        // Fire and response on lane 3 together.
        bus.req_valid = 4'b0001; bus.req_readLane = 8'h03;
        cycle();
        bus.req_valid = '0; bus.resp_valid = 4'b1000;
        cycle();
        checkVal("same_cycle_fire", 64'(lastFire), 64'(4'b0001));
        bus.resp_valid = '0;
        cycle();
        checkVal("same_cycle_cred", 64'(credOf(lastCredit, 3)), 64'(CREDITS));

        // Flush with all four held.
        readyMask = 4'h0; bus.req_valid = 4'hF; bus.req_readLane = 8'hE4;
        cycle();
        flush = 1'b1;
        cycle();
        checkVal("flush_busy_before", 64'(lastBusy), 64'(1));
        checkVal("flush_ready", 64'(lastReady), 64'(0));
        savedCred = lastCredit;
        flush = 1'b0; bus.req_valid = '0;
        cycle();
        checkVal("flush_busy", 64'(lastBusy), 64'(0));
        checkVal("flush_xv", 64'(lastXv), 64'(0));
        checkVal("flush_cred", 64'(lastCredit), 64'(savedCred));

        // Mid-stream asynchronous reset.
        for (int k = 0; k < 6; k++) begin
            randomInputs();
            flush = 1'b0;
            cycle();
        end
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int k = 0; k < 1500; k++) begin
            randomInputs();
            cycle();
        end
        doReset();
        for (int k = 0; k < 500; k++) begin
            randomInputs();
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mask_unit_read_scheduler.md
Name: mask_unit_read_scheduler

Overview:
- Front-end controller for the mask unit's 4x4 read crossbar, which grants by fixed priority (input 0 highest).
- Registers the read requests of four requesters and presents them to the crossbar inputs.
- Age counters stop low-priority requesters from starving.
- Per-lane credits cap outstanding reads on each of the four read lanes; lane responses return the credits.

Parameters:
- STARVE_LIMIT, 8: cycles a held request may wait before it gets forced priority (1..255).
- CREDITS, 2: maximum outstanding reads per read lane (1..7).
- CNT_W, $clog2(CREDITS+1): width of each credit counter (derived).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all held requests.
- req_valid  in  4  per-requester request valid.
- req_ready  out  4  per-requester ready.
- req_vs  in  20  packed 4x5 vector register.
- req_offset  in  24  packed 4x6 offset.
- req_readLane  in  8  packed 4x2 target lane.
- req_dataOffset  in  8  packed 4x2 data offset.
- xbar_valid  out  4  to crossbar input_i_valid.
- xbar_ready  in  4  from crossbar input_i_ready.
- xbar_vs, xbar_offset, xbar_readLane, xbar_dataOffset  out  20/24/8/8  held fields to the crossbar.
- resp_valid  in  4  per-lane one-cycle pulse; each pulse returns one credit.
- credit  out  4*CNT_W  packed current credit per lane.
- busy  out  1  any holding register valid.
- credit_err  out  1  sticky; a response arrived on a lane already at CREDITS.

Behaviour:
- Reset: clock and reset are the single clock and an asynchronous active-high reset.
  - On reset, all hold_valid=0 and all ages=0.
  - Every credit=CREDITS and credit_err=0.
  - Outputs at reset: xbar_valid=0, busy=0, req_ready=4'hF.
- Holding stage, per requester i:
  - One register: hold_valid_i plus the four fields.
  - req_ready_i = ~hold_valid_i | fire_i, where fire_i = xbar_valid_i & xbar_ready_i.
  - On req_valid_i & req_ready_i the register loads (or stays valid); otherwise it clears on fire_i.
  - Minimum latency from request to crossbar is 1 cycle; a back-to-back stream runs at full rate.
- Crossbar fields are driven directly from the holding registers. The crossbar ready does not depend on its own input's valid, so the path has no combinational loop.
- Credit gate: elig_i = hold_valid_i & (credit[readLane_i] != 0).
- Age counter, per requester:
  - Increments when hold_valid_i & ~fire_i, saturating at STARVE_LIMIT.
  - Clears to 0 on fire_i or when the register is empty.
  - A newly loaded request on the fire cycle starts at age 0.
- Starvation override:
  - starved_i = elig_i & (age_i == STARVE_LIMIT).
  - s is the lowest-index starved requester.
  - When s exists, xbar_valid_j = 0 for every j != s with readLane_j == readLane_s. Non-conflicting lanes are unaffected.
  - With no starved requester, xbar_valid_i = elig_i.
- Credits, per lane L, updated each cycle:
  - Minus 1 if any fire_i targets L (the crossbar grants at most one per lane per cycle).
  - Plus 1 if resp_valid[L].
  - Fire and response on the same lane in the same cycle leave the credit unchanged.
  - A response while credit==CREDITS with no same-cycle fire leaves the credit at CREDITS and sets credit_err.
  - credit never underflows, because zero credit blocks elig.
- flush:
  - Clears all hold_valid and ages next edge; in-flight crossbar handshakes that cycle still count against credits.
  - Credits and credit_err are preserved.
  - req_ready is forced 0 during flush, so no request is accepted.
- busy = |hold_valid.
- Mid-operation reset: every state element returns to its reset value immediately (asynchronous); outstanding lane responses after reset are counted toward credit_err only if they overflow.

Test Plan:
- Reset, then requester 2 sends readLane=1, vs=5'h3, xbar_ready all 1 -> xbar_valid=4'b0100 on cycle 1, credit lane1 goes 2->1, req_ready[2] stays 1.
- Requesters 0 and 3 both send readLane=0 every cycle, STARVE_LIMIT=8, resp_valid[0] every cycle -> requester 3 waits exactly 8 cycles, is then granted while xbar_valid[0]=0, and its age returns to 0.
- CREDITS=2, three requests to lane 2, no responses -> two fire, the third holds with xbar_valid=0 and credit lane2=0; one resp_valid[2] pulse -> the third fires the cycle after the credit returns.
- resp_valid[1] with credit lane1 = CREDITS -> credit stays 2, credit_err=1 and stays set until reset.
- Fire and resp_valid on lane 3 in the same cycle -> credit lane3 unchanged.
- flush with all four holding registers valid -> next cycle busy=0, xbar_valid=0, credits unchanged; reset asserted mid-stream -> outputs return to their reset values without a clock edge.
